// File: rtl/mips_mc_ctrl_v2.sv
// Multicycle MIPS control FSM with memory handshake, stall timeout and retirement pulse.
// Optional: define ILLEGAL_OP_TRAP_EN to trap undefined opcodes instead of retiring them as NOPs.
module mips_mc_ctrl_v2 #(
    parameter int OP_W       = 6,
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic [1:0]      RegDst,
    output logic [1:0]      MemtoReg,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic            ExtOp,
    output logic [1:0]      PCSource,
    output logic [2:0]      ALUOp,
    output logic            instr_done,
    output logic            mem_err,
    output logic [3:0]      state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_ILLEGAL = 1'b1;
`else
    localparam bit TRAP_ILLEGAL = 1'b0;
`endif

    // Stall budget expressed as the count value seen on the last allowed stall cycle.
    localparam logic [CNT_W-1:0] LIMIT_M1 =
        (WAIT_LIMIT == 0) ? '0 : CNT_W'(WAIT_LIMIT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   stall_cnt;
    logic               mem_err_q;
    logic               mem_state;
    logic               timeout;
    logic               op_legal;
    logic               illegal_trap;

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    assign mem_state    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout      = (WAIT_LIMIT != 0) && mem_state && !mem_ready && (stall_cnt == LIMIT_M1);
    assign illegal_trap = TRAP_ILLEGAL && (state == S_DECODE) && !op_legal;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:                      state_nxt = S_MEMADR;
                    OP_RTYPE:                          state_nxt = S_RTEX;
                    OP_BEQ:                            state_nxt = S_BEQ;
                    OP_BNE:                            state_nxt = S_BNE;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = S_IMMEX;
                    OP_J:                              state_nxt = S_JUMP;
                    OP_JAL:                            state_nxt = S_JAL;
                    default: state_nxt = TRAP_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)    state_nxt = S_MEMWB;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)    state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_RTEX:  state_nxt = S_RTWB;
            S_IMMEX: state_nxt = S_IMMWB;
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            stall_cnt <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counter only runs while a memory state is held waiting on mem_ready.
            if (mem_ready || !mem_state || (state_nxt != state)) begin
                stall_cnt <= '0;
            end else if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (timeout || illegal_trap) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ExtOp       = 1'b1;
        PCSource    = 2'b00;
        ALUOp       = 3'b000;
        instr_done  = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                instr_done = !op_legal && !TRAP_ILLEGAL;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_RTEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            S_RTWB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                ALUOp       = (state == S_BEQ) ? 3'b001 : 3'b011;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = !((op == OP_ANDI) || (op == OP_ORI));
                case (op)
                    OP_ANDI: ALUOp = 3'b100;
                    OP_ORI:  ALUOp = 3'b101;
                    OP_SLTI: ALUOp = 3'b110;
                    default: ALUOp = 3'b000;
                endcase
            end
            S_IMMWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                ExtOp      = !((op == OP_ANDI) || (op == OP_ORI));
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_JAL: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_TRAP: ;
            default: ExtOp = 1'b0;
        endcase
        // Reset overrides asynchronously to the FETCH decode with every write enable held off.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b1;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 2'b00;
            MemtoReg    = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b01;
            ExtOp       = 1'b1;
            PCSource    = 2'b00;
            ALUOp       = 3'b000;
            instr_done  = 1'b0;
        end
    end

    assign mem_err   = mem_err_q && !rst;
    assign state_dbg = rst ? 4'd0 : state;

endmodule
